// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and default widths for the APB round-robin arbiter
package apb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    typedef struct packed {
        logic [DEF_DATA_W-1:0]          rdata;
        logic                           err;
        logic [$clog2(DEF_NUM_REQ)-1:0] id;
    } apb_rsp_t;

endpackage

// File: rtl/apb_rr_arbiter_if.sv
// rtl/apb_rr_arbiter_if.sv - APB bus bundle between the shared master and the slave
interface apb_rr_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational round-robin picker starting the search at ptr
module rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk the requesters from ptr upward with wrap; first asserted one wins
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - round-robin sharing of one APB master port with a wait-state watchdog
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      pclk,
    input  logic                      preset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    apb_rr_arbiter_if.master          apb
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    id_q;
    logic [CNT_W-1:0]   wait_q;
    logic [CNT_W-1:0]   wait_d;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [DATA_W-1:0]  rsp_rdata_q;
    logic               rsp_err_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_idx;
    logic               accept;
    logic               timeout_hit;
    logic [ID_W-1:0]    ptr_d;

    rr_arb #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (grant),
        .idx (win_idx)
    );

    // Grants are only offered while the bus is free
    assign req_ready   = (state_q == IDLE) ? grant : '0;
    assign accept      = (state_q == IDLE) && (|(req_valid & grant));
    assign ptr_d       = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    // wait_d is the number of ACCESS cycles elapsed including the current one
    assign wait_d      = wait_q + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (wait_d == CNT_W'(TIMEOUT));

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;

    // Transfer sequencer: command latch, APB phases, watchdog and response register
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            wait_q      <= '0;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwrite  <= 1'b0;
            apb.paddr   <= '0;
            apb.pwdata  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        apb.pwrite <= req_write[win_idx];
                        apb.paddr  <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                        apb.pwdata <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
                        apb.psel   <= 1'b1;
                        id_q       <= win_idx;
                        ptr_q      <= ptr_d;
                        wait_q     <= '0;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    apb.penable <= 1'b1;
                    state_q     <= ACCESS;
                end
                ACCESS: begin
                    // pready in the final watchdog cycle still wins over the timeout
                    if (apb.pready) begin
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_err_q   <= apb.pslverr;
                        rsp_rdata_q <= (!apb.pwrite && !apb.pslverr) ? apb.prdata : '0;
                        state_q     <= IDLE;
                    end else if (timeout_hit) begin
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= IDLE;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                default: begin
                    apb.psel    <= 1'b0;
                    apb.penable <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule
